sr_flag_arbiter: RTL and testbench

Interrupt flag controller for Slipstream. It owns a bank of NSRC set/reset pending flags: source rising edges set a flag, and CPU acknowledge clears it. A fixed-priority arbiter presents one enabled pending flag at a time to the CPU as a request plus vector. The Ack/EOI handshake serialises servicing. The block sits between the peripheral event sources (video, blitter, DSP, timers) and the CPU interrupt input. All state is registered on MasterClock.

---
 rtl/sr_flag_arbiter.sv | 119 +++++++++++
 tb/tb_sr_flag_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// Pending-flag bank with a fixed-priority presenter for the CPU interrupt input.
// Each source rising edge sets a flag. An Ack clears it. An Ack/Eoi handshake serialises servicing.
module sr_flag_arbiter #(
   parameter int NSRC = 8,
   parameter int VW   = 3
) (
   input  logic            MasterClock,
   input  logic            RESETL,
   input  logic [NSRC-1:0] SrcReq,
   input  logic            MaskWr,
   input  logic [NSRC-1:0] MaskData,
   input  logic            Ack,
   input  logic            Eoi,
   output logic            IntReq,
   output logic [VW-1:0]   IntVec,
   output logic [NSRC-1:0] Pending,
   output logic            InService
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} stateT;

   stateT           stateReg, stateNext;
   logic [NSRC-1:0] srcPrevReg;
   logic [NSRC-1:0] pendingReg, pendingNext;
   logic [NSRC-1:0] maskReg, maskNext;
   logic            armedReg;
   logic            intReqReg, intReqNext;
   logic [VW-1:0]   intVecReg, intVecNext;
   logic            inServiceReg, inServiceNext;

   logic [NSRC-1:0] setBit, clrBit, eligible;
   logic [VW-1:0]   winner;

   // armedReg blocks edge detection on the first edge after reset.
   // A source that is held high through reset therefore needs a fresh rising edge.
   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : gFlag
         assign setBit[gi]      = armedReg & SrcReq[gi] & ~srcPrevReg[gi];
         assign clrBit[gi]      = (stateReg == REQ) & Ack & (intVecReg == VW'(gi));
         assign pendingNext[gi] = setBit[gi] | (pendingReg[gi] & ~clrBit[gi]);
      end
   endgenerate

   assign eligible = pendingReg & maskReg;
   assign maskNext = MaskWr ? MaskData : maskReg;

   always_comb begin
      winner = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = VW'(i);
      end
   end

   always_comb begin
      stateNext     = stateReg;
      intReqNext    = intReqReg;
      intVecNext    = intVecReg;
      inServiceNext = inServiceReg;
      case (stateReg)
         IDLE: begin
            if (eligible != '0) begin
               intVecNext = winner;
               intReqNext = 1'b1;
               stateNext  = REQ;
            end
         end
         REQ: begin
            if (Ack) begin
               intReqNext    = 1'b0;
               inServiceNext = 1'b1;
               stateNext     = SERVICE;
            end else if (!eligible[intVecReg]) begin
               intReqNext = 1'b0;
               stateNext  = IDLE;
            end
         end
         SERVICE: begin
            if (Eoi) begin
               inServiceNext = 1'b0;
               stateNext     = IDLE;
            end
         end
         default: begin
            stateNext     = IDLE;
            intReqNext    = 1'b0;
            inServiceNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge MasterClock or negedge RESETL) begin
      if (!RESETL) begin
         stateReg     <= IDLE;
         srcPrevReg   <= '0;
         pendingReg   <= '0;
         maskReg      <= '0;
         armedReg     <= 1'b0;
         intReqReg    <= 1'b0;
         intVecReg    <= '0;
         inServiceReg <= 1'b0;
      end else begin
         stateReg     <= stateNext;
         srcPrevReg   <= SrcReq;
         pendingReg   <= pendingNext;
         maskReg      <= maskNext;
         armedReg     <= 1'b1;
         intReqReg    <= intReqNext;
         intVecReg    <= intVecNext;
         inServiceReg <= inServiceNext;
      end
   end

   assign IntReq    = intReqReg;
   assign IntVec    = intVecReg;
   assign Pending   = pendingReg;
   assign InService = inServiceReg;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed-vector bench for sr_flag_arbiter.
// Inputs are driven 1 time unit after each rising edge, and outputs are checked at the same point.
module tb_sr_flag_arbiter;

   logic       MasterClock = 1'b0;
   logic       RESETL = 1'b0;
   logic [7:0] SrcReq = '0;
   logic       MaskWr = 1'b0;
   logic [7:0] MaskData = '0;
   logic       Ack = 1'b0;
   logic       Eoi = 1'b0;
   logic       IntReq;
   logic [2:0] IntVec;
   logic [7:0] Pending;
   logic       InService;

   int testCount = 0;
   int failCount = 0;

   sr_flag_arbiter #(.NSRC(8), .VW(3)) dut (
      .MasterClock(MasterClock),
      .RESETL(RESETL),
      .SrcReq(SrcReq),
      .MaskWr(MaskWr),
      .MaskData(MaskData),
      .Ack(Ack),
      .Eoi(Eoi),
      .IntReq(IntReq),
      .IntVec(IntVec),
      .Pending(Pending),
      .InService(InService)
   );

   always #5 MasterClock = ~MasterClock;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge MasterClock);
      #1;
   endtask

   task automatic writeMask(input logic [7:0] m);
      MaskWr = 1'b1; MaskData = m;
      tick();
      MaskWr = 1'b0;
   endtask

   task automatic pulseSrc(input int idx);
      SrcReq[idx] = 1'b1;
      tick();
      SrcReq[idx] = 1'b0;
   endtask

   task automatic doAck();
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
   endtask

   task automatic doEoi();
      Eoi = 1'b1;
      tick();
      Eoi = 1'b0;
   endtask

   initial begin
      logic [2:0] expVec [3];
      logic [7:0] expPend [3];
      expVec  = '{3'd2, 3'd4, 3'd6};
      expPend = '{8'h50, 8'h40, 8'h00};

      // Reset state
      #3;
      checkVal("rst IntReq", 32'(IntReq), 0);
      checkVal("rst IntVec", 32'(IntVec), 0);
      checkVal("rst Pending", 32'(Pending), 0);
      checkVal("rst InService", 32'(InService), 0);
      tick();
      RESETL = 1'b1;
      tick(); tick();

      // Basic sequence on source 3
      writeMask(8'hFF);
      pulseSrc(3);
      checkVal("basic Pending", 32'(Pending), 32'h08);
      checkVal("basic IntReq early", 32'(IntReq), 0);
      tick();
      checkVal("basic IntReq", 32'(IntReq), 1);
      checkVal("basic IntVec", 32'(IntVec), 3);
      tick(); tick();
      checkVal("basic IntReq held", 32'(IntReq), 1);
      doAck();
      checkVal("basic ack IntReq", 32'(IntReq), 0);
      checkVal("basic ack Pending", 32'(Pending), 0);
      checkVal("basic ack InService", 32'(InService), 1);
      tick();
      doEoi();
      checkVal("basic eoi InService", 32'(InService), 0);
      tick();
      checkVal("basic idle IntReq", 32'(IntReq), 0);

      // Priority without preemption: source 5 is presented before source 1
      SrcReq[5] = 1'b1;
      tick();
      SrcReq[5] = 1'b0; SrcReq[1] = 1'b1;
      tick();
      SrcReq[1] = 1'b0;
      checkVal("prio IntVec first", 32'(IntVec), 5);
      checkVal("prio Pending", 32'(Pending), 32'h22);
      tick();
      checkVal("prio no preempt", 32'(IntVec), 5);
      doAck();
      checkVal("prio ack Pending", 32'(Pending), 32'h02);
      doEoi();
      checkVal("prio gap IntReq", 32'(IntReq), 0);
      tick();
      checkVal("prio second IntReq", 32'(IntReq), 1);
      checkVal("prio second IntVec", 32'(IntVec), 1);
      doAck(); doEoi();

      // Simultaneous rising edges on sources 2, 4 and 6
      SrcReq = 8'h54;
      tick();
      SrcReq = 8'h00;
      checkVal("simul Pending", 32'(Pending), 32'h54);
      tick();
      for (int k = 0; k < 3; k++) begin
         checkVal($sformatf("simul IntVec%0d", k), 32'(IntVec), 32'(expVec[k]));
         doAck();
         checkVal($sformatf("simul Pending%0d", k), 32'(Pending), 32'(expPend[k]));
         doEoi();
         tick();
      end
      checkVal("simul done IntReq", 32'(IntReq), 0);

      // Masking
      writeMask(8'h00);
      pulseSrc(0);
      checkVal("mask Pending", 32'(Pending), 32'h01);
      tick(); tick();
      checkVal("mask IntReq off", 32'(IntReq), 0);
      writeMask(8'h01);
      checkVal("mask wr edge IntReq", 32'(IntReq), 0);
      tick();
      checkVal("mask IntReq on", 32'(IntReq), 1);
      checkVal("mask IntVec", 32'(IntVec), 0);
      writeMask(8'h00);
      checkVal("mask req hold", 32'(IntReq), 1);
      tick();
      checkVal("mask withdraw IntReq", 32'(IntReq), 0);
      checkVal("mask retained Pending", 32'(Pending), 32'h01);
      tick();
      doAck();
      checkVal("ack idle Pending", 32'(Pending), 32'h01);
      checkVal("ack idle InService", 32'(InService), 0);

      // Clear the leftover flag, then test a set/clear collision and stray strobes
      writeMask(8'hFF);
      tick();
      checkVal("mask reenable IntVec", 32'(IntVec), 0);
      doAck(); doEoi();
      pulseSrc(3);
      tick();
      checkVal("coll IntVec", 32'(IntVec), 3);
      doEoi();
      checkVal("eoi in req IntReq", 32'(IntReq), 1);
      checkVal("eoi in req InService", 32'(InService), 0);
      SrcReq[3] = 1'b1; Ack = 1'b1;
      tick();
      SrcReq[3] = 1'b0; Ack = 1'b0;
      checkVal("coll Pending", 32'(Pending), 32'h08);
      checkVal("coll InService", 32'(InService), 1);
      doAck();
      checkVal("ack svc InService", 32'(InService), 1);
      checkVal("ack svc Pending", 32'(Pending), 32'h08);
      doEoi();
      tick();
      checkVal("coll represent IntVec", 32'(IntVec), 3);
      checkVal("coll represent IntReq", 32'(IntReq), 1);
      Ack = 1'b1; Eoi = 1'b1;
      tick();
      Ack = 1'b0; Eoi = 1'b0;
      checkVal("ack+eoi InService", 32'(InService), 1);
      doEoi();

      // Asynchronous reset during SERVICE with source 2 held high
      SrcReq[2] = 1'b1;
      tick(); tick();
      checkVal("rst2 IntVec", 32'(IntVec), 2);
      doAck();
      checkVal("rst2 in service", 32'(InService), 1);
      #2 RESETL = 1'b0;
      #1;
      checkVal("rst2 IntReq", 32'(IntReq), 0);
      checkVal("rst2 InService", 32'(InService), 0);
      checkVal("rst2 IntVec0", 32'(IntVec), 0);
      checkVal("rst2 Pending", 32'(Pending), 0);
      tick();
      #2 RESETL = 1'b1;
      tick();
      writeMask(8'hFF);
      tick(); tick();
      checkVal("rst2 held no retrigger", 32'(Pending), 0);
      checkVal("rst2 held IntReq", 32'(IntReq), 0);
      SrcReq[2] = 1'b0;
      tick();
      SrcReq[2] = 1'b1;
      tick();
      checkVal("rst2 fresh Pending", 32'(Pending), 32'h04);
      tick();
      checkVal("rst2 fresh IntReq", 32'(IntReq), 1);
      checkVal("rst2 fresh IntVec", 32'(IntVec), 2);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
